// File: rtl/serial_vartheta_unit_pkg.sv
// Shared definitions for the serial vartheta unit: FSM encoding, default
// geometry and rotation amounts.
package serial_vartheta_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRot  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefBlockSize = 128;
  localparam int unsigned DefPa        = 1;
  localparam int unsigned DefPb        = 3;
  localparam int unsigned DefPc        = 13;

  // A half-block is split into four columns.
  function automatic int unsigned column_size(input int unsigned block_size);
    return block_size / 8;
  endfunction

endpackage

// File: rtl/swan_col_rotate.sv
// Combinational rotation of one column, index 0 being the MSB; right moves
// index i to i+amt, left moves it to i-amt (both modulo the column width).
module swan_col_rotate
  import serial_vartheta_unit_pkg::*;
#(
  parameter int unsigned COLUMN_SIZE = column_size(DefBlockSize),
  parameter int unsigned MAX_ROT     = COLUMN_SIZE - 1,
  localparam int unsigned AmtW       = (MAX_ROT > 0) ? $clog2(MAX_ROT + 1) : 1
) (
  input  logic [0:COLUMN_SIZE-1] i_col,
  input  logic [AmtW-1:0]        i_amt,
  input  logic                   i_left,
  output logic [0:COLUMN_SIZE-1] o_col
);

  logic [2*COLUMN_SIZE-1:0] w_dbl;
  logic [2*COLUMN_SIZE-1:0] w_shr;
  logic [2*COLUMN_SIZE-1:0] w_shl;

  // Shifting a doubled copy yields the rotation in one half without any bit loss.
  always_comb begin
    w_dbl = {i_col, i_col};
    w_shr = w_dbl >> i_amt;
    w_shl = w_dbl << i_amt;
    if (i_left) begin
      o_col = w_shl[2*COLUMN_SIZE-1:COLUMN_SIZE];
    end else begin
      o_col = w_shr[COLUMN_SIZE-1:0];
    end
  end

endmodule

// File: rtl/serial_vartheta_unit.sv
// Column-serial vartheta transform: rotates one column per cycle through a
// shared rotator, with a valid/ready handshake on both sides.
module serial_vartheta_unit
  import serial_vartheta_unit_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE   = DefBlockSize,
  parameter int unsigned PA           = DefPa,
  parameter int unsigned PB           = DefPb,
  parameter int unsigned PC           = DefPc,
  localparam int unsigned SIDE_SIZE   = BLOCK_SIZE / 2,
  localparam int unsigned COLUMN_SIZE = column_size(BLOCK_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inv,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y
);

  localparam int unsigned AmtW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;

  if ((BLOCK_SIZE == 0) || ((BLOCK_SIZE % 8) != 0)) begin : g_bad_block_size
    $error("serial_vartheta_unit: BLOCK_SIZE must be a nonzero multiple of 8");
  end
  if ((PA >= COLUMN_SIZE) || (PB >= COLUMN_SIZE) || (PC >= COLUMN_SIZE)) begin : g_bad_rot
    $error("serial_vartheta_unit: rotation amounts must be below COLUMN_SIZE");
  end

  state_e                 r_state;
  state_e                 w_state_d;
  logic [1:0]             r_cnt;
  logic                   r_inv;
  logic [0:SIDE_SIZE-1]   r_work;
  logic [0:SIDE_SIZE-1]   w_rot_work;
  logic [0:COLUMN_SIZE-1] w_cols [4];
  logic [0:COLUMN_SIZE-1] w_col_out;
  logic [AmtW-1:0]        w_amt;
  logic                   w_accept;

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign w_cols[g] = r_work[g*COLUMN_SIZE +: COLUMN_SIZE];
    assign w_rot_work[g*COLUMN_SIZE +: COLUMN_SIZE] =
        (r_cnt == 2'(g)) ? w_col_out : w_cols[g];
  end

  always_comb begin
    w_amt = '0;
    case (r_cnt)
      2'd0:    w_amt = AmtW'(PC);
      2'd1:    w_amt = AmtW'(PB);
      2'd2:    w_amt = AmtW'(PA);
      default: w_amt = '0;
    endcase
  end

  swan_col_rotate #(
    .COLUMN_SIZE (COLUMN_SIZE),
    .MAX_ROT     (COLUMN_SIZE - 1)
  ) u_col_rotate (
    .i_col  (w_cols[r_cnt]),
    .i_amt  (w_amt),
    .i_left (r_inv),
    .o_col  (w_col_out)
  );

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        in_ready = ~rst;
        if (in_valid && !rst) w_state_d = StRot;
      end
      StRot: begin
        if (r_cnt == 2'd3) w_state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~rst;
        if (out_ready) w_state_d = in_valid ? StRot : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign y        = r_work;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_work <= x;
        r_inv  <= inv;
        r_cnt  <= '0;
      end else if (r_state == StRot) begin
        r_work <= w_rot_work;
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_vartheta_unit.sv
// Directed and round-trip bench for serial_vartheta_unit at 128- and 256-bit block sizes.
module tb_serial_vartheta_unit;

  localparam int Pa = 1;
  localparam int Pb = 3;
  localparam int Pc = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_in_valid, a_in_ready, a_inv, a_out_valid, a_out_ready;
  logic [0:63] a_x, a_y;
  logic b_in_valid, b_in_ready, b_inv, b_out_valid, b_out_ready;
  logic [0:127] b_x, b_y;

  int checks   = 0;
  int failures = 0;

  serial_vartheta_unit u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .inv       (a_inv),
    .x         (a_x),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .y         (a_y)
  );

  serial_vartheta_unit #(.BLOCK_SIZE(256)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .inv       (b_inv),
    .x         (b_x),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .y         (b_y)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-by-bit model; xin is right-aligned, column 0 in the most significant bits.
  function automatic logic [127:0] ref_vt(input logic [127:0] xin, input bit inv_in, input int cs);
    int rot [4];
    int side, dst;
    logic [127:0] res;
    rot[0] = Pc; rot[1] = Pb; rot[2] = Pa; rot[3] = 0;
    side = 4 * cs;
    res  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < cs; i++) begin
        dst = inv_in ? (i - rot[c] + cs) % cs : (i + rot[c]) % cs;
        res[side-1-(c*cs+dst)] = xin[side-1-(c*cs+i)];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] a_y_w();
    return {64'h0, a_y};
  endfunction

  task automatic do_op(input bit big, input logic [127:0] xin, input bit inv_in,
                       input string tag, output logic [127:0] yout);
    int lat;
    @(negedge clk);
    if (big) begin
      b_x = xin; b_inv = inv_in; b_in_valid = 1'b1;
    end else begin
      a_x = xin[63:0]; a_inv = inv_in; a_in_valid = 1'b1;
    end
    lat = 0;
    while (!(big ? b_in_ready : a_in_ready) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " in_ready"}, 128'(big ? b_in_ready : a_in_ready), 128'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!(big ? b_out_valid : a_out_valid) && lat < 20);
    check_eq({tag, " latency"}, 128'(lat), 128'd4);
    yout = big ? 128'(b_y) : a_y_w();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [127:0] yo, yo2, xr, y0;
    logic         stable;
    int           lat;

    rst = 1'b1;
    a_in_valid = 1'b0; a_inv = 1'b0; a_x = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_inv = 1'b0; b_x = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst a out_valid", 128'(a_out_valid), 128'd0);
    check_eq("rst a y", a_y_w(), 128'd0);
    check_eq("rst a in_ready", 128'(a_in_ready), 128'd0);
    check_eq("rst b y", 128'(b_y), 128'd0);
    check_eq("rst b in_ready", 128'(b_in_ready), 128'd0);
    rst = 1'b0;
    #1;
    check_eq("idle a in_ready", 128'(a_in_ready), 128'd1);

    // 128-bit directed vectors
    do_op(1'b0, 128'h8000_8000_8000_8000, 1'b0, "a fwd msb", yo);
    check_eq("a fwd msb y", yo, 128'h0004_1000_4000_8000);
    do_op(1'b0, 128'h0001_0001_0001_0001, 1'b0, "a fwd lsb", yo);
    check_eq("a fwd lsb y", yo, 128'h0008_2000_8000_0001);
    do_op(1'b0, 128'h0004_1000_4000_8000, 1'b1, "a inv msb", yo);
    check_eq("a inv msb y", yo, 128'h8000_8000_8000_8000);
    do_op(1'b0, 128'h0008_2000_8000_0001, 1'b1, "a inv lsb", yo);
    check_eq("a inv lsb y", yo, 128'h0001_0001_0001_0001);

    // 256-bit directed vectors
    do_op(1'b1, 128'h80000000_80000000_80000000_80000000, 1'b0, "b fwd msb", yo);
    check_eq("b fwd msb y", yo, 128'h00040000_10000000_40000000_80000000);
    do_op(1'b1, 128'h00040000_10000000_40000000_80000000, 1'b1, "b inv msb", yo);
    check_eq("b inv msb y", yo, 128'h80000000_80000000_80000000_80000000);

    // Backpressure, then back-to-back accept with input activity during ROT
    a_out_ready = 1'b0;
    do_op(1'b0, 128'h8000_8000_8000_8000, 1'b0, "a bp", y0);
    check_eq("a bp y", y0, 128'h0004_1000_4000_8000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_y_w() !== y0 || a_in_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("a bp hold", 128'(stable), 128'd1);
    a_out_ready = 1'b1;
    a_x = 64'h0001_0001_0001_0001;
    a_inv = 1'b0;
    a_in_valid = 1'b1;
    #1;
    check_eq("a b2b in_ready", 128'(a_in_ready), 128'd1);
    @(posedge clk);
    #1;
    a_x = 64'hDEAD_BEEF_1234_5678;
    a_inv = 1'b1;
    @(negedge clk);
    check_eq("a b2b valid drop", 128'(a_out_valid), 128'd0);
    check_eq("a rot in_ready", 128'(a_in_ready), 128'd0);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("a b2b latency", 128'(lat), 128'd4);
    check_eq("a b2b y", a_y_w(), 128'h0008_2000_8000_0001);

    // Reset while cnt=2 abandons the block
    @(negedge clk);
    a_out_ready = 1'b0;
    a_x = 64'h8000_8000_8000_8000; a_inv = 1'b0; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("a mid rst in_ready", 128'(a_in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("a post rst out_valid", 128'(a_out_valid), 128'd0);
    check_eq("a post rst y", a_y_w(), 128'd0);
    check_eq("a post rst idle", 128'(a_in_ready), 128'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_out_valid !== 1'b0) stable = 1'b0;
    end
    check_eq("a post rst no output", 128'(stable), 128'd1);
    a_out_ready = 1'b1;
    do_op(1'b0, 128'h0001_0001_0001_0001, 1'b0, "a after rst", yo);
    check_eq("a after rst y", yo, 128'h0008_2000_8000_0001);

    // Random round trips against the model for both sizes
    for (int n = 0; n < 1000; n++) begin
      xr = {64'h0, $urandom(), $urandom()};
      do_op(1'b0, xr, 1'b0, "a rnd fwd", yo);
      check_eq("a rnd fwd y", yo, ref_vt(xr, 1'b0, 16));
      do_op(1'b0, yo, 1'b1, "a rnd inv", yo2);
      check_eq("a rnd round trip", yo2, xr);
    end
    for (int n = 0; n < 1000; n++) begin
      xr = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_op(1'b1, xr, 1'b0, "b rnd fwd", yo);
      check_eq("b rnd fwd y", yo, ref_vt(xr, 1'b0, 32));
      do_op(1'b1, yo, 1'b1, "b rnd inv", yo2);
      check_eq("b rnd round trip", yo2, xr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_vartheta_unit.md
SERIAL_VARTHETA_UNIT -- requirements
Module: serial_vartheta_unit

Interface
REQ-001 The block SHALL have parameter BLOCK_SIZE, default 128: cipher block width in bits.
REQ-002 The block SHALL have parameter PA, default 1: rotation amount for column 2.
REQ-003 The block SHALL have parameter PB, default 3: rotation amount for column 1.
REQ-004 The block SHALL have parameter PC, default 13: rotation amount for column 0.
REQ-005 The block SHALL have derived constant SIDE_SIZE = BLOCK_SIZE/2 and derived constant COLUMN_SIZE = SIDE_SIZE/4.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port in_valid, input, 1 bit: x and inv are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a new input.
REQ-010 The block SHALL have port inv, input, 1 bit: 0 selects the forward transform, 1 selects the inverse transform.
REQ-011 The block SHALL have port x, input, SIDE_SIZE bits, indexed [0:SIDE_SIZE-1] with index 0 as MSB: input half-block.
REQ-012 The block SHALL have port out_valid, output, 1 bit: y holds a completed result.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-014 The block SHALL have port y, output, SIDE_SIZE bits, indexed [0:SIDE_SIZE-1]: result half-block.

Function
REQ-015 The block SHALL split x into columns c0..c3, where column c0 is x[0:COLUMN_SIZE-1] and column c3 is x[3*COLUMN_SIZE:SIDE_SIZE-1].
REQ-016 The block SHALL use rotation table R = {PC, PB, PA, 0} for columns c0..c3 respectively.
REQ-017 In forward mode, the block SHALL rotate each column right by R: the bit at index i moves to index (i+R) mod COLUMN_SIZE.
REQ-018 In inverse mode, the block SHALL rotate each column left by R: the bit at index i moves to index (i-R) mod COLUMN_SIZE.
REQ-019 The block SHALL implement an FSM with states IDLE, ROT and DONE.
REQ-020 A handshake SHALL occur when in_valid and in_ready are both 1 at a clk edge; the block SHALL then register x and inv, clear the column counter cnt (2 bits) to 0, and enter ROT.
REQ-021 In each ROT cycle, the block SHALL rotate only column cnt of the working register by R[cnt] and increment cnt.
REQ-022 When cnt=3 in ROT, the block SHALL enter DONE at the next edge.
REQ-023 Column 3 SHALL still consume one ROT cycle even though its rotation amount is zero.
REQ-024 Latency SHALL be 4 clk cycles: for a handshake at edge k, out_valid SHALL be 1 after edge k+4.
REQ-025 In DONE, out_valid SHALL be 1, and y and out_valid SHALL hold stable until out_ready is 1.
REQ-026 In DONE with out_ready=1 and in_valid=0, the block SHALL go to IDLE and set out_valid to 0.
REQ-027 in_ready SHALL be the combinational function (state==IDLE) OR (state==DONE AND out_ready).
REQ-028 In DONE with out_ready=1 and in_valid=1, the block SHALL accept the new input at the same edge and enter ROT (back-to-back operation; sustained period of 5 cycles per block).
REQ-029 Changes on x, inv or in_valid while in ROT SHALL have no effect on the operation in progress.
REQ-030 in_valid=1 while in ROT SHALL not be lost; it SHALL remain pending under the consumer's responsibility, since in_ready=0 during ROT.
REQ-031 Every rotation SHALL be width-preserving, with no bit lost or duplicated.
REQ-032 Rotation amounts PA, PB and PC SHALL each be less than COLUMN_SIZE.
REQ-033 BLOCK_SIZE SHALL be a multiple of 8; an elaboration-time check SHALL flag any violation of this or of REQ-032.

Reset
REQ-034 While rst=1 at a clk edge, the block SHALL set the state to IDLE, cnt to 0, the working register to 0, y to 0 and out_valid to 0.
REQ-035 While rst=1, in_ready SHALL be 0.
REQ-036 A reset asserted mid-operation (in ROT or DONE) SHALL abandon the current block with no output produced; the first handshake after rst deasserts SHALL start a fresh operation.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (IDLE, ROT, DONE), the default BLOCK_SIZE, PA, PB and PC, and the function that derives COLUMN_SIZE.
REQ-038 The block SHALL use one combinational sub-module, swan_col_rotate (parameters COLUMN_SIZE and a rotation amount, plus a direction input), instantiated once and shared across columns via cnt.

Verification
REQ-039 With BLOCK_SIZE=128, x=64'h8000_8000_8000_8000 and inv=0 -> y=64'h0004_1000_4000_8000, with out_valid 4 cycles after the handshake.
REQ-040 With x=64'h0001_0001_0001_0001 and inv=0 -> y=64'h0008_2000_8000_0001.
REQ-041 Inverse round trip: feed y=64'h0004_1000_4000_8000 with inv=1 -> y=64'h8000_8000_8000_8000; repeat over 1000 random words, checking that inv(fwd(x)) equals x.
REQ-042 Backpressure: hold out_ready=0 for 10 cycles in DONE -> y and out_valid remain stable and in_ready=0; then assert out_ready together with in_valid -> next block accepted at that same edge, with the next out_valid 5 cycles later.
REQ-043 Assert rst for one cycle while cnt=2 -> out_valid stays 0, and y=0 and state IDLE on the next cycle; a subsequent input then produces the correct result after 4 cycles.
REQ-044 Re-run REQ-039 through REQ-041 with BLOCK_SIZE=256 (COLUMN_SIZE=32) against a reference model.
